alu_uart_bridge: RTL



---
 rtl/alu_uart_bridge.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_uart_bridge.sv
// alu_uart_bridge
//   Glue between a UART receiver, a combinational ALU and a UART transmitter.
//   Collects three received bytes (A, B, opcode) and holds them on the ALU
//   inputs. One settle cycle later it captures the ALU result and issues a
//   single-cycle transmit request. It then waits for the transmitter to finish.
//
// Optional build macro: ALU_BRIDGE_OPCHECK_EN
//   When this macro is defined, opcodes outside the supported ALU set are
//   rejected. o_alu_op keeps its old value, and 0xEE is sent in place of the
//   result. Frame timing is the same either way.
//
// Ports
//   i_clk, i_reset        clock, async active-high reset
//   i_rx_done/i_rx_data   byte strobe + byte from the UART receiver
//   i_alu_result          combinational ALU output
//   i_tx_done             end-of-stop-bit strobe from the transmitter
//   o_alu_a/b/op          registered ALU operands / opcode
//   o_tx_data/o_tx_start  byte to send + one-cycle start pulse
//   o_busy                high while a frame is executing or transmitting
//   o_overrun             sticky: a byte arrived while busy and was dropped
module alu_uart_bridge #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_overrun
);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX
  } state_t;

  state_t state, state_nxt;

  // state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= WAIT_A;
    else         state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_A:  if (i_rx_done) state_nxt = WAIT_B;
      WAIT_B:  if (i_rx_done) state_nxt = WAIT_OP;
      WAIT_OP: if (i_rx_done) state_nxt = EXEC;
      EXEC:    state_nxt = SEND;
      SEND:    state_nxt = WAIT_TX;
      WAIT_TX: if (i_tx_done) state_nxt = WAIT_A;
      default: state_nxt = WAIT_A;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    o_busy = 1'b0;
    case (state)
      EXEC, SEND, WAIT_TX: o_busy = 1'b1;
      default:             o_busy = 1'b0;
    endcase
  end

  logic [NB_OP-1:0] rx_op;
  assign rx_op = i_rx_data[NB_OP-1:0];

`ifdef ALU_BRIDGE_OPCHECK_EN
  function automatic logic op_ok(input logic [NB_OP-1:0] op);
    case (op)
      NB_OP'(8'h20), NB_OP'(8'h22), NB_OP'(8'h24), NB_OP'(8'h25),
      NB_OP'(8'h26), NB_OP'(8'h27), NB_OP'(8'h03), NB_OP'(8'h02): op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  endfunction

  // Remembers that the current frame carried a rejected opcode.
  logic op_bad;
`endif

  // The start pulse is registered so it lines up with the captured data and
  // is cleared by the async reset immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_overrun  <= 1'b0;
`ifdef ALU_BRIDGE_OPCHECK_EN
      op_bad     <= 1'b0;
`endif
    end else begin
      o_tx_start <= (state == SEND);
      if (i_rx_done && o_busy) o_overrun <= 1'b1;
      case (state)
        WAIT_A:  if (i_rx_done) o_alu_a <= i_rx_data;
        WAIT_B:  if (i_rx_done) o_alu_b <= i_rx_data;
        WAIT_OP: if (i_rx_done) begin
`ifdef ALU_BRIDGE_OPCHECK_EN
          op_bad <= !op_ok(rx_op);
          if (op_ok(rx_op)) o_alu_op <= rx_op;
`else
          o_alu_op <= rx_op;
`endif
        end
        SEND: begin
`ifdef ALU_BRIDGE_OPCHECK_EN
          o_tx_data <= op_bad ? NB_DATA'(8'hEE) : i_alu_result;
`else
          o_tx_data <= i_alu_result;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
